// File: rtl/count_pwm_gen_if.sv
// Duty-cycle request channel: a requested high-time offered with valid/ready.
// Transfer happens on the rising edge where duty_valid && duty_ready.
interface count_pwm_gen_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/count_pwm_gen.sv
// Purpose: period-aligned PWM from a free-running counter, with wrap/period/sequence monitors.
// Latency: pwm_out and wrap_pulse lag cnt_in by one clock.
// Backpressure: one pending duty slot; duty_ready low while it is full, until the next load point.
module count_pwm_gen #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    count_pwm_gen_if.slave    duty_if,
    input  logic              pwm_en,
    input  logic              err_clr,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic [PCNT_W-1:0] period_cnt,
    output logic              seq_err
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_prev_q, cnt_prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic               wrap_q, wrap_d;
    logic               seq_err_q, seq_err_d;
    logic [PCNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic               pwm_q, pwm_d;
    logic [WIDTH-1:0]   active_q, active_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               pend_full_q, pend_full_d;

    logic               wrap_now;
    logic               step_ok;
    logic               load_pt;
    logic               xfer;
    logic [WIDTH-1:0]   duty_next;

    always_comb begin
        state_d      = state_q;
        cnt_prev_d   = cnt_in;
        prev_vld_d   = 1'b1;
        period_cnt_d = period_cnt_q;
        pwm_d        = 1'b0;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;

        wrap_now = prev_vld_q && (cnt_prev_q == CNT_MAX) && (cnt_in == '0);
        wrap_d   = wrap_now;

        // A jump to zero is the counter's own reset, so it is a legal step.
        step_ok = (cnt_in == cnt_prev_q) || (cnt_in == cnt_prev_q + CNT_ONE) || (cnt_in == '0);
        if (prev_vld_q && !step_ok) begin
            seq_err_d = 1'b1;
        end else if (err_clr) begin
            seq_err_d = 1'b0;
        end else begin
            seq_err_d = seq_err_q;
        end

        load_pt = ((state_q == RUN) && wrap_now)
               || ((state_q == ARMED) && pwm_en && (cnt_in == '0));
        duty_next = (load_pt && pend_full_q) ? pend_q : active_q;
        active_d  = duty_next;

        // The slot is never filled and drained on the same edge: ready is low while full.
        xfer = duty_if.duty_valid && !pend_full_q;
        if (load_pt && pend_full_q) begin
            pend_full_d = 1'b0;
        end else if (xfer) begin
            pend_d      = duty_if.duty_in;
            pend_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pwm_en) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!pwm_en) begin
                    state_d = IDLE;
                end else if (cnt_in == '0) begin
                    // Start comparing on the aligning edge so the first period is whole.
                    state_d = RUN;
                    pwm_d   = (cnt_in < duty_next);
                end
            end
            RUN: begin
                if (wrap_now) begin
                    period_cnt_d = period_cnt_q + PCNT_W'(1);
                end
                if (!pwm_en) begin
                    state_d = IDLE;
                end else begin
                    pwm_d = (cnt_in < duty_next);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_prev_q   <= '0;
            prev_vld_q   <= 1'b0;
            wrap_q       <= 1'b0;
            seq_err_q    <= 1'b0;
            period_cnt_q <= '0;
            pwm_q        <= 1'b0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_prev_q   <= cnt_prev_d;
            prev_vld_q   <= prev_vld_d;
            wrap_q       <= wrap_d;
            seq_err_q    <= seq_err_d;
            period_cnt_q <= period_cnt_d;
            pwm_q        <= pwm_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
        end
    end

    assign pwm_out            = pwm_q;
    assign wrap_pulse         = wrap_q;
    assign period_cnt         = period_cnt_q;
    assign seq_err            = seq_err_q;
    assign duty_if.duty_ready = !pend_full_q;
endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen: the bench drives the counter value itself,
// so legal sequences, counter resets and illegal jumps are all explicit.
module tb_count_pwm_gen;
    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       pwm_en;
    logic       err_clr;
    logic       pwm_out;
    logic       wrap_pulse;
    logic [7:0] period_cnt;
    logic       seq_err;

    int n_chk;
    int n_fail;

    count_pwm_gen_if #(.WIDTH(4)) pif ();

    count_pwm_gen #(.WIDTH(4), .PCNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .duty_if    (pif),
        .pwm_en     (pwm_en),
        .err_clr    (err_clr),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse),
        .period_cnt (period_cnt),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the end of test");
        $fatal(1, "watchdog");
    end

    // Apply one counter value and return 1 time unit after the edge that consumed it.
    task automatic drive(input int c);
        cnt_in = c[3:0];
        @(posedge clk);
        #1;
    endtask

    // One full counter period 0..15; optionally offers a duty write for one cycle at wr_at.
    task automatic run_period(input int duty, input int wr_at, input int wr_val,
                              output int highs, output int mism, output int wraps,
                              output int rdy_lo);
        highs = 0; mism = 0; wraps = 0; rdy_lo = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == wr_at) begin
                pif.duty_valid = 1'b1;
                pif.duty_in    = wr_val[3:0];
            end
            drive(c);
            if (c == wr_at) pif.duty_valid = 1'b0;
            if (pwm_out !== (c < duty)) mism++;
            if (pwm_out === 1'b1) highs++;
            if (wrap_pulse === 1'b1) wraps++;
            if (pif.duty_ready !== 1'b1) rdy_lo++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pwm_en = 1'b1; err_clr = 1'b0;
        pif.duty_valid = 1'b1; pif.duty_in = 4'd9;
        for (int i = 0; i < 3; i++) drive(i * 5 + 2);
        n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_out: got %b expected 0", pwm_out); end
        n_chk++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_pulse: got %b expected 0", wrap_pulse); end
        n_chk++; if (period_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_period_cnt: got %0d expected 0", period_cnt); end
        n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
        n_chk++; if (pif.duty_ready !== 1'b1) begin n_fail++; $display("FAIL reset_duty_ready: got %b expected 1", pif.duty_ready); end
        pwm_en = 1'b0; pif.duty_valid = 1'b0; pif.duty_in = 4'd0;
        cnt_in = 4'd0;
        rst = 1'b1;
    endtask

    task automatic test_basic_pwm();
        int h, m, w, r;
        pif.duty_valid = 1'b1; pif.duty_in = 4'd5;
        drive(0);
        pif.duty_valid = 1'b0;
        n_chk++; if (pif.duty_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_low: got %b expected 0", pif.duty_ready); end
        pwm_en = 1'b1;
        for (int c = 1; c < 16; c++) drive(c);
        n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL armed_pwm_low: got %b expected 0", pwm_out); end
        for (int p = 0; p < 2; p++) begin
            run_period(5, -1, 0, h, m, w, r);
            n_chk++; if (h !== 5) begin n_fail++; $display("FAIL basic_highs p%0d: got %0d expected 5", p, h); end
            n_chk++; if (m !== 0) begin n_fail++; $display("FAIL basic_shape p%0d: got %0d wrong clocks expected 0", p, m); end
            n_chk++; if (w !== 1) begin n_fail++; $display("FAIL basic_wraps p%0d: got %0d expected 1", p, w); end
        end
        n_chk++; if (period_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_period_cnt: got %0d expected 1", period_cnt); end
    endtask

    task automatic test_duty_update();
        int h, m, w, r;
        run_period(5, 7, 12, h, m, w, r);
        n_chk++; if (h !== 5 || m !== 0) begin n_fail++; $display("FAIL upd_old_duty: got %0d highs %0d wrong expected 5/0", h, m); end
        n_chk++; if (r !== 9) begin n_fail++; $display("FAIL upd_ready_low: got %0d clocks expected 9", r); end
        run_period(12, 3, 9, h, m, w, r);
        n_chk++; if (h !== 12 || m !== 0) begin n_fail++; $display("FAIL upd_new_duty: got %0d highs %0d wrong expected 12/0", h, m); end
        n_chk++; if (r !== 13) begin n_fail++; $display("FAIL upd_ready_low2: got %0d clocks expected 13", r); end
        pif.duty_valid = 1'b1; pif.duty_in = 4'd2;
        n_chk++; if (pif.duty_ready !== 1'b0) begin n_fail++; $display("FAIL upd_full_holdoff: got %b expected 0", pif.duty_ready); end
        run_period(9, 1, 2, h, m, w, r);
        n_chk++; if (h !== 9 || m !== 0) begin n_fail++; $display("FAIL upd_queued_duty: got %0d highs %0d wrong expected 9/0", h, m); end
        n_chk++; if (r !== 15) begin n_fail++; $display("FAIL upd_ready_low3: got %0d clocks expected 15", r); end
        run_period(2, -1, 0, h, m, w, r);
        n_chk++; if (h !== 2 || m !== 0) begin n_fail++; $display("FAIL upd_held_write: got %0d highs %0d wrong expected 2/0", h, m); end
    endtask

    task automatic test_duty_extremes();
        int h, m, w, r;
        run_period(2, 5, 0, h, m, w, r);
        run_period(0, 5, 15, h, m, w, r);
        n_chk++; if (h !== 0) begin n_fail++; $display("FAIL duty0_highs: got %0d expected 0", h); end
        run_period(15, -1, 0, h, m, w, r);
        n_chk++; if (h !== 15 || m !== 0) begin n_fail++; $display("FAIL duty15: got %0d highs %0d wrong expected 15/0", h, m); end
    endtask

    task automatic test_seq_check();
        logic [7:0] pc;
        for (int c = 0; c < 8; c++) drive(c);
        pc = period_cnt;
        drive(0);
        n_chk++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL cntrst_no_wrap: got %b expected 0", wrap_pulse); end
        n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL cntrst_no_err: got %b expected 0", seq_err); end
        n_chk++; if (period_cnt !== pc) begin n_fail++; $display("FAIL cntrst_period: got %0d expected %0d", period_cnt, pc); end
        n_chk++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL cntrst_run: got %b expected 1", pwm_out); end
        for (int c = 1; c < 4; c++) drive(c);
        drive(9);
        n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL bad_step_set: got %b expected 1", seq_err); end
        drive(10);
        n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", seq_err); end
        err_clr = 1'b1;
        drive(11);
        n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", seq_err); end
        drive(5);
        n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b expected 1", seq_err); end
        err_clr = 1'b0;
        drive(6);
        n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky2: got %b expected 1", seq_err); end
        err_clr = 1'b1;
        drive(7);
        err_clr = 1'b0;
        for (int c = 8; c < 16; c++) drive(c);
        n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL err_clear2: got %b expected 0", seq_err); end
    endtask

    task automatic test_enable();
        int h, m, w, r, hi;
        logic [7:0] pc0;
        drive(0);
        pc0 = period_cnt;
        for (int c = 1; c < 4; c++) drive(c);
        pwm_en = 1'b0;
        drive(4);
        n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL disable_pwm: got %b expected 0", pwm_out); end
        for (int c = 5; c < 16; c++) drive(c);
        drive(0);
        n_chk++; if (wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL idle_wrap_pulse: got %b expected 1", wrap_pulse); end
        n_chk++; if (period_cnt !== pc0) begin n_fail++; $display("FAIL idle_period_hold: got %0d expected %0d", period_cnt, pc0); end
        pwm_en = 1'b1;
        hi = 0;
        for (int c = 1; c < 16; c++) begin
            drive(c);
            if (pwm_out === 1'b1) hi++;
        end
        n_chk++; if (hi !== 0) begin n_fail++; $display("FAIL armed_quiet: got %0d highs expected 0", hi); end
        run_period(15, -1, 0, h, m, w, r);
        n_chk++; if (h !== 15 || m !== 0) begin n_fail++; $display("FAIL resume_shape: got %0d highs %0d wrong expected 15/0", h, m); end
        n_chk++; if (period_cnt !== pc0) begin n_fail++; $display("FAIL resume_period: got %0d expected %0d", period_cnt, pc0); end
        run_period(15, -1, 0, h, m, w, r);
        n_chk++; if (period_cnt !== pc0 + 8'd1) begin n_fail++; $display("FAIL resume_period_inc: got %0d expected %0d", period_cnt, pc0 + 8'd1); end
    endtask

    task automatic test_period_wrap();
        int h, m, w, r;
        int guard;
        guard = 0;
        while (period_cnt !== 8'd255 && guard < 300) begin
            run_period(15, -1, 0, h, m, w, r);
            guard++;
        end
        n_chk++; if (period_cnt !== 8'd255) begin n_fail++; $display("FAIL pcnt_reach_max: got %0d expected 255", period_cnt); end
        run_period(15, -1, 0, h, m, w, r);
        n_chk++; if (period_cnt !== 8'd0) begin n_fail++; $display("FAIL pcnt_wrap: got %0d expected 0", period_cnt); end
        n_chk++; if (h !== 15 || w !== 1) begin n_fail++; $display("FAIL pcnt_wrap_run: got %0d highs %0d wraps expected 15/1", h, w); end
    endtask

    task automatic test_reset_mid();
        int h, m, w, r;
        pif.duty_valid = 1'b1; pif.duty_in = 4'd3;
        drive(0);
        pif.duty_valid = 1'b0;
        for (int c = 1; c < 4; c++) drive(c);
        n_chk++; if (pif.duty_ready !== 1'b0 || pwm_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got ready %b pwm %b expected 0/1", pif.duty_ready, pwm_out); end
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (pwm_out !== 1'b0 || period_cnt !== 8'd0 || seq_err !== 1'b0 || wrap_pulse !== 1'b0)
            begin n_fail++; $display("FAIL mid_async_reset: got pwm %b pcnt %0d err %b wrap %b expected 0/0/0/0", pwm_out, period_cnt, seq_err, wrap_pulse); end
        n_chk++; if (pif.duty_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", pif.duty_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 4; c < 16; c++) drive(c);
        run_period(0, -1, 0, h, m, w, r);
        n_chk++; if (h !== 0) begin n_fail++; $display("FAIL pending_lost: got %0d highs expected 0", h); end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cnt_in = 4'd0;
        pwm_en = 1'b0;
        err_clr = 1'b0;
        pif.duty_valid = 1'b0;
        pif.duty_in = 4'd0;
        rst = 1'b1;
        #1;
        test_reset();
        test_basic_pwm();
        test_duty_update();
        test_duty_extremes();
        test_seq_check();
        test_enable();
        test_period_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
